// File: rtl/result_checker.sv
// result_checker: aligns operands to result latency, compares DUT vs reference q, counts and captures first failure (optional STOP_ON_ERR_EN halts on first mismatch)
module result_checker #(
  parameter int N   = 8,
  parameter int LAT = 1,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          c_in,
  input  logic          op_code,
  input  logic [N-1:0]  q_dut,
  input  logic [N-1:0]  q_ref,
  output logic          err_flag,
  output logic          sticky_err,
  output logic [CW-1:0] check_count,
  output logic [CW-1:0] err_count,
  output logic [N-1:0]  first_a,
  output logic [N-1:0]  first_b,
  output logic          first_op,
  output logic          first_cin,
  output logic          halt
);
  typedef enum logic [1:0] {
    IDLE, PASSING, FAILED
`ifdef STOP_ON_ERR_EN
    , HALTED
`endif
  } state_t;
  state_t state_q;
  logic [LAT-1:0] v_q;
  logic [N-1:0] a_q [LAT];
  logic [N-1:0] b_q [LAT];
  logic [LAT-1:0] c_q, op_q;
  logic chk, mm;
  logic err_flag_q, sticky_q, first_op_q, first_cin_q;
  logic [CW-1:0] chk_cnt_q, chk_cnt_d, err_cnt_q, err_cnt_d;
  logic [N-1:0] first_a_q, first_b_q;
`ifdef STOP_ON_ERR_EN
  logic halt_q;
  assign chk  = v_q[LAT-1] && state_q != HALTED;
  assign halt = halt_q;
`else
  assign chk  = v_q[LAT-1];
  assign halt = 1'b0;
`endif
  assign mm = chk && (q_dut !== q_ref);
  // saturating next values for both counters
  always_comb begin
    chk_cnt_d = (chk && ~&chk_cnt_q) ? chk_cnt_q + 1'b1 : chk_cnt_q;
    err_cnt_d = (mm && ~&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  // operand alignment pipeline; stage LAT-1 lines up with q_dut/q_ref, and clr leaves it shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      c_q  <= '0;
      op_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      v_q[0]  <= en;
      a_q[0]  <= a;
      b_q[0]  <= b;
      c_q[0]  <= c_in;
      op_q[0] <= op_code;
      for (int i = 1; i < LAT; i++) begin
        v_q[i]  <= v_q[i-1];
        a_q[i]  <= a_q[i-1];
        b_q[i]  <= b_q[i-1];
        c_q[i]  <= c_q[i-1];
        op_q[i] <= op_q[i-1];
      end
    end
  end
  // check FSM with counters, sticky flag and first-failure capture; clr outranks a same-cycle check
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      state_q     <= IDLE;
      err_flag_q  <= 1'b0;
      sticky_q    <= 1'b0;
      chk_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_op_q  <= 1'b0;
      first_cin_q <= 1'b0;
`ifdef STOP_ON_ERR_EN
      halt_q      <= 1'b0;
`endif
    end else begin
      err_flag_q <= mm;
      chk_cnt_q  <= chk_cnt_d;
      err_cnt_q  <= err_cnt_d;
      if (mm && (state_q == IDLE || state_q == PASSING)) begin
        first_a_q   <= a_q[LAT-1];
        first_b_q   <= b_q[LAT-1];
        first_op_q  <= op_q[LAT-1];
        first_cin_q <= c_q[LAT-1];
        sticky_q    <= 1'b1;
`ifdef STOP_ON_ERR_EN
        state_q     <= HALTED;
        halt_q      <= 1'b1;
`else
        state_q     <= FAILED;
`endif
      end else if (chk && state_q == IDLE) begin
        state_q <= PASSING;
      end
    end
  end
  assign err_flag    = err_flag_q;
  assign sticky_err  = sticky_q;
  assign check_count = chk_cnt_q;
  assign err_count   = err_cnt_q;
  assign first_a     = first_a_q;
  assign first_b     = first_b_q;
  assign first_op    = first_op_q;
  assign first_cin   = first_cin_q;
endmodule
